// File: rtl/key_map_pkg.sv
// Shared types and constants for the key action mapper: channel FSM state
// encoding, PS/2 set-2 scan codes and the default WASD/space channel map.
package key_map_pkg;

  typedef logic [1:0] key_state_t;

  localparam key_state_t ST_IDLE   = 2'd0;
  localparam key_state_t ST_DELAY  = 2'd1;
  localparam key_state_t ST_REPEAT = 2'd2;

  localparam logic [8:0] KC_W     = 9'h01D;
  localparam logic [8:0] KC_A     = 9'h01C;
  localparam logic [8:0] KC_S     = 9'h01B;
  localparam logic [8:0] KC_D     = 9'h023;
  localparam logic [8:0] KC_SPACE = 9'h029;

  // Channel 0 sits in the least significant nine bits.
  localparam logic [44:0] KEY_CODES_DEFAULT = {KC_SPACE, KC_D, KC_S, KC_A, KC_W};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_typematic.sv
// One key channel: held-level sample register plus press pulse generator.
// Auto-repeat (DELAY/REPEAT states and counter) exists only with KEY_REPEAT_EN.
module key_typematic
  import key_map_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic clk,
  input  logic rst_p,
  input  logic sample,
  output logic held,
  output logic press
);

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("key_typematic: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic held_r;
  logic press_r;

  assign held  = held_r;
  assign press = press_r;

`ifdef KEY_REPEAT_EN
  localparam int CNT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  // Counters count down to zero, so the terminal edge is load value + 1 cycles later.
  localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

  key_state_t       state_r;
  key_state_t       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             press_nxt_s;

  // Typematic next state: a low sample always returns to IDLE with a clear counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    press_nxt_s = 1'b0;
    if (!sample) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          press_nxt_s = 1'b1;
          cnt_nxt_s   = DELAY_LOAD;
          state_nxt_s = ST_DELAY;
        end
        ST_DELAY: begin
          if (cnt_r == '0) begin
            press_nxt_s = 1'b1;
            cnt_nxt_s   = PERIOD_LOAD;
            state_nxt_s = ST_REPEAT;
          end else begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (cnt_r == '0) begin
            press_nxt_s = 1'b1;
            cnt_nxt_s   = PERIOD_LOAD;
          end else begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // Channel state, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) begin
      held_r  <= 1'b0;
      press_r <= 1'b0;
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      held_r  <= sample;
      press_r <= press_nxt_s;
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end
`else
  // Held level and rising-edge press pulse only.
  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) begin
      held_r  <= 1'b0;
      press_r <= 1'b0;
    end else begin
      held_r  <= sample;
      press_r <= sample & ~held_r;
    end
  end
`endif

endmodule

// File: rtl/key_action_mapper.sv
// Maps NUM_KEYS scan codes to held/press channels and tracks the most
// recently pressed mapped key. Auto-repeat is built when KEY_REPEAT_EN is defined.
module key_action_mapper
  import key_map_pkg::*;
#(
  parameter int                    NUM_KEYS      = 5,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = KEY_CODES_DEFAULT,
  parameter int                    REPEAT_DELAY  = 50,
  parameter int                    REPEAT_PERIOD = 10
) (
  input  logic                                               clk,
  input  logic                                               rst_p,
  input  logic [511:0]                                       key_down,
  input  logic [8:0]                                         last_change,
  input  logic                                               key_valid,
  output logic [NUM_KEYS-1:0]                                key_held,
  output logic [NUM_KEYS-1:0]                                key_press,
  output logic [((NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1)-1:0] last_idx,
  output logic                                               last_vld
);

  localparam int LIDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  logic [NUM_KEYS-1:0] sample_s;
  logic [NUM_KEYS-1:0] held_s;
  logic [NUM_KEYS-1:0] press_s;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    assign sample_s[i] = key_down[KEY_CODES[9*i +: 9]];

    key_typematic #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_typematic (
      .clk    (clk),
      .rst_p  (rst_p),
      .sample (sample_s[i]),
      .held   (held_s[i]),
      .press  (press_s[i])
    );
  end

  assign key_held  = held_s;
  assign key_press = press_s;

  logic              hit_s;
  logic [LIDX_W-1:0] hit_idx_s;
  logic              last_fall_s;
  logic              press_ev_s;
  logic [LIDX_W-1:0] last_idx_r;
  logic              last_vld_r;

  // Lowest matching channel for last_change, and release of the tracked key
  // this cycle (its held level is about to fall).
  always_comb begin
    hit_s       = 1'b0;
    hit_idx_s   = '0;
    last_fall_s = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      hit_idx_s   = (last_change == KEY_CODES[9*i +: 9]) ? LIDX_W'(i) : hit_idx_s;
      hit_s       = hit_s | (last_change == KEY_CODES[9*i +: 9]);
      last_fall_s = last_fall_s |
                    ((last_idx_r == LIDX_W'(i)) & held_s[i] & ~sample_s[i]);
    end
  end

  assign press_ev_s = key_valid & key_down[last_change] & hit_s;

  // Last-pressed tracking; a new press outranks a simultaneous release.
  always_ff @(posedge clk or negedge rst_p) begin
    if (!rst_p) begin
      last_idx_r <= '0;
      last_vld_r <= 1'b0;
    end else if (press_ev_s) begin
      last_idx_r <= hit_idx_s;
      last_vld_r <= 1'b1;
    end else if (last_fall_s) begin
      last_vld_r <= 1'b0;
    end
  end

  assign last_idx = last_idx_r;
  assign last_vld = last_vld_r;

endmodule

// File: tb/tb_key_action_mapper.sv
// Scoreboard bench for key_action_mapper (default parameters); expects
// auto-repeat pulses only when KEY_REPEAT_EN is defined.
module tb_key_action_mapper;

`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  localparam int DLY = 50;
  localparam int PER = 10;

  typedef struct packed {
    logic [4:0] held;
    logic [4:0] press;
    logic [2:0] lidx;
    logic       lvld;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_p;
  logic [511:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic [4:0]   key_held;
  logic [4:0]   key_press;
  logic [2:0]   last_idx;
  logic         last_vld;

  key_action_mapper dut (
    .clk         (clk),
    .rst_p       (rst_p),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_press   (key_press),
    .last_idx    (last_idx),
    .last_vld    (last_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [8:0] codes [5] = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h029};

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  int   press_cnt [5];

  logic [4:0] m_held;
  int         m_age [5];
  logic [2:0] m_idx;
  logic       m_vld;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 5'd0;
    m_idx  = 3'd0;
    m_vld  = 1'b0;
    for (int i = 0; i < 5; i++) m_age[i] = 0;
  endtask

  // Behavioural expectation for the edge that ends the current cycle.
  task automatic model_step(input logic vld, input logic [8:0] lc, output exp_t e);
    logic [4:0] s;
    logic [4:0] pr;
    logic       fall;
    int         hit;
    for (int i = 0; i < 5; i++) s[i] = key_down[codes[i]];
    fall = m_held[m_idx] & ~s[m_idx];
    hit  = -1;
    for (int i = 4; i >= 0; i--) if (lc == codes[i]) hit = i;
    for (int i = 0; i < 5; i++) begin
      if (s[i]) begin
        m_age[i] = m_held[i] ? m_age[i] + 1 : 0;
        pr[i] = (m_age[i] == 0) ||
                (REP && m_age[i] >= DLY && ((m_age[i] - DLY) % PER) == 0);
      end else begin
        m_age[i] = 0;
        pr[i]    = 1'b0;
      end
    end
    if (vld && key_down[lc] && hit >= 0) begin
      m_idx = 3'(hit);
      m_vld = 1'b1;
    end else if (fall) begin
      m_vld = 1'b0;
    end
    m_held  = s;
    e.held  = m_held;
    e.press = pr;
    e.lidx  = m_idx;
    e.lvld  = m_vld;
  endtask

  // Drive one cycle of stimulus, then compare the DUT against the queued expectation.
  task automatic cycle(input logic vld, input logic [8:0] lc);
    exp_t e;
    exp_t got;
    key_valid   = vld;
    last_change = lc;
    model_step(vld, lc, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_val("held",  key_held,  got.held);
    check_val("press", key_press, got.press);
    check_val("lidx",  last_idx,  got.lidx);
    check_val("lvld",  last_vld,  got.lvld);
    for (int i = 0; i < 5; i++) press_cnt[i] += key_press[i];
    key_valid   = 1'b0;
    last_change = 9'h000;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 9'h000);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 5; i++) press_cnt[i] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_held"},  key_held,  32'd0);
    check_val({tag, "_press"}, key_press, 32'd0);
    check_val({tag, "_lidx"},  last_idx,  32'd0);
    check_val({tag, "_lvld"},  last_vld,  32'd0);
  endtask

  initial begin
    rst_p       = 1'b0;
    key_down    = 512'd0;
    last_change = 9'h000;
    key_valid   = 1'b0;
    model_reset();
    clear_counts();
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    rst_p = 1'b1;

    // W held three cycles: one pulse, no repeat.
    key_down[9'h01D] = 1'b1;
    idle(3);
    key_down[9'h01D] = 1'b0;
    idle(3);
    check_val("w_pulses", press_cnt[0], 32'd1);

    // D held 75 cycles: pulses at T, T+50, T+60, T+70 when repeating.
    clear_counts();
    key_down[9'h023] = 1'b1;
    idle(75);
    key_down[9'h023] = 1'b0;
    idle(5);
    check_val("d_pulses", press_cnt[3], REP ? 32'd4 : 32'd1);

    // Last-pressed tracking: A then S, release S.
    key_down[9'h01C] = 1'b1;
    cycle(1'b1, 9'h01C);
    check_val("lidx_a", last_idx, 32'd1);
    idle(2);
    key_down[9'h01B] = 1'b1;
    cycle(1'b1, 9'h01B);
    check_val("lidx_s", last_idx, 32'd2);
    idle(2);
    key_down[9'h01B] = 1'b0;
    cycle(1'b1, 9'h01B);
    idle(2);
    check_val("rel_lvld", last_vld, 32'd0);
    check_val("rel_lidx", last_idx, 32'd2);

    // Release of tracked S coincides with a SPACE press: the press wins.
    key_down[9'h01B] = 1'b1;
    cycle(1'b1, 9'h01B);
    idle(1);
    key_down[9'h01B] = 1'b0;
    key_down[9'h029] = 1'b1;
    cycle(1'b1, 9'h029);
    check_val("race_lidx", last_idx, 32'd4);
    check_val("race_lvld", last_vld, 32'd1);
    idle(2);

    // Unmapped code pressed: nothing changes.
    key_down[9'h015] = 1'b1;
    cycle(1'b1, 9'h015);
    check_val("unmap_lidx", last_idx, 32'd4);
    idle(1);
    key_down = 512'd0;
    idle(3);

    // Simultaneous presses pulse together.
    clear_counts();
    key_down[9'h01C] = 1'b1;
    key_down[9'h023] = 1'b1;
    cycle(1'b0, 9'h000);
    check_val("simul_press", key_press, 32'h0A);
    key_down = 512'd0;
    idle(2);

    // Reset during DELAY with W held, then release while still held.
    key_down[9'h01D] = 1'b1;
    idle(10);
    #2;
    rst_p = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("hold_rst");
    rst_p = 1'b1;
    clear_counts();
    cycle(1'b0, 9'h000);
    check_val("rst_repress", key_press[0], 32'd1);
    idle(3);
    key_down = 512'd0;
    idle(2);

    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_action_mapper.md
# key_action_mapper

- Parametrised successor to the fixed WASD/space key-state decode.
- Takes the 512-bit `key_down` vector and `last_change`/`key_valid` from `KeyboardDecoder`.
- Produces, for NUM_KEYS configurable scan codes:
  - registered held levels;
  - one-cycle press pulses with typematic auto-repeat;
  - a "most recently pressed" channel index.
- Sits between `KeyboardDecoder` and game control logic; replaces ad-hoc per-key decode.

## Interface
Parameters:
- NUM_KEYS, 5, number of mapped key channels (1..16)
- KEY_CODES, {9'h029, 9'h023, 9'h01B, 9'h01C, 9'h01D}, packed NUM_KEYS×9 scan codes; channel i = bits [9i+8:9i] (default: 0=W, 1=A, 2=S, 3=D, 4=SPACE)
- REPEAT_DELAY, 50, cycles from first press pulse to first repeat pulse (≥1)
- REPEAT_PERIOD, 10, cycles between subsequent repeat pulses (≥1)

Ports:
- clk  in  1  block clock (100 Hz domain in the top level)
- rst_p  in  1  reset; asynchronous, active-low
- key_down  in  512  per-scan-code held vector from `KeyboardDecoder`
- last_change  in  9  scan code of the latest make/break event
- key_valid  in  1  one-cycle strobe qualifying `last_change`
- key_held  out  NUM_KEYS  registered held level per channel
- key_press  out  NUM_KEYS  one-cycle pulse per channel on press and on each auto-repeat
- last_idx  out  $clog2(NUM_KEYS) (min 1)  channel index of most recently pressed mapped key
- last_vld  out  1  `last_idx` refers to a key still held

## Operation
- All outputs reset to 0. Reset is asynchronous and may assert at any time; it clears all FSMs and counters.
- Each channel i samples `key_down[KEY_CODES[i]]` into `key_held[i]` every cycle.
- Per-channel FSM:
  - States: IDLE, DELAY, REPEAT. Counter width CNT_W = $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - IDLE: on rising `key_held` → pulse `key_press[i]`, load the counter, go to DELAY.
  - DELAY: count REPEAT_DELAY cycles. At terminal count, pulse, reload with REPEAT_PERIOD, go to REPEAT.
  - REPEAT: at each terminal count, pulse and reload.
  - From any state, a low sample → IDLE and counter cleared. Release never produces a pulse.
- Last-pressed tracking:
  - On `key_valid` with `key_down[last_change]`=1 and `last_change` equal to some KEY_CODES[i] → `last_idx`<=i, `last_vld`<=1.
  - Duplicate codes: lowest channel index wins.
  - When `key_held[last_idx]` falls → `last_vld`<=0; `last_idx` holds its value.
  - If a new mapped press and the release of the current `last_idx` key occur in the same cycle, the press wins (`last_vld` stays 1, index updates).
  - Unmapped codes and break events do not change `last_idx`.
- After reset deassertion with a key already down, the channel sees a rising edge and emits a press pulse on the first sample.

## Timing
- `key_held`: 1-cycle latency from `key_down`.
- First `key_press`: same cycle `key_held` first reads 1, i.e. 1 cycle after `key_down`.
- Repeat pulses, with first pulse at cycle T: T+REPEAT_DELAY, then +REPEAT_PERIOD each.
- `last_idx`/`last_vld`: update the cycle after `key_valid`.
- Held keys are independent: simultaneous presses pulse simultaneously.

## Configuration
- KEY_REPEAT_EN defined: typematic FSM as above.
- KEY_REPEAT_EN undefined:
  - DELAY/REPEAT states and counters are not built.
  - `key_press` pulses only on rising `key_held`.
  - All other behaviour is identical.

## Structure
- `key_map_pkg` holds:
  - the FSM state typedef (IDLE/DELAY/REPEAT);
  - scan-code constants KC_W 9'h01D, KC_A 9'h01C, KC_S 9'h01B, KC_D 9'h023, KC_SPACE 9'h029;
  - the default KEY_CODES concatenation.
- Sub-module `key_typematic`: one instance per channel via generate. Contains sample register, FSM, counter. Outputs `held` and `press`.
- The top level holds only the last-pressed logic.

## Test plan
- Reset, then hold W (key_down[0x1D]) for 3 cycles → `key_held[0]` high from cycle +1, single `key_press[0]` pulse, no repeat.
- Hold D for 75 cycles (defaults) → pulses at T, T+50, T+60, T+70; release → `key_held[3]` low next cycle, no further pulse.
- Press A (key_valid, last_change=0x1C), then S → `last_idx`=1 then 2, `last_vld`=1. Release S → `last_vld`=0, `last_idx` remains 2.
- Same cycle: release of S and key_valid press of SPACE → `last_idx`=4, `last_vld` stays 1.
- key_valid with unmapped code 0x15 pressed → no change to any output.
- Assert rst_p low during DELAY while holding W → all outputs 0 immediately. Deassert while held → fresh pulse on first sample. Rerun with KEY_REPEAT_EN undefined → no repeat pulses in the 75-cycle hold test.
